// File: rtl/load_store_unit.sv
// RV32I load/store unit: word-aligned memory port, sub-word loads with extension,
// sub-word stores via read-modify-write. Optional macro: LSU_ALIGN_CHECK_EN.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  function automatic logic illegal_funct3(input logic we, input logic [2:0] f3);
    if (we)
      illegal_funct3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else
      illegal_funct3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                         f3 == F3_BU || f3 == F3_HU);
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; only enforced when checking is built in.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = lane[0];
      2'b10:   mis = (lane != 2'b00);
      default: mis = 1'b0;
    endcase
    misaligned = ALIGN_CHECK && mis;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    extract = {{24{b[7]}}, b};
      F3_BU:   extract = {24'h0, b};
      F3_H:    extract = {{16{h[15]}}, h};
      F3_HU:   extract = {16'h0, h};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] lane,
                                        input logic [31:0] word, input logic [31:0] data);
    logic [31:0] m;
    m = word;
    if (f3[1:0] == 2'b00)
      m[8*lane +: 8] = data[7:0];
    else if (lane[1])
      m[31:16] = data[15:0];
    else
      m[15:0] = data[15:0];
    merge = m;
  endfunction

  assign req_ready = (state == IDLE) && !reset;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            if (illegal_funct3(req_we, req_funct3) ||
                misaligned(req_funct3, req_addr[1:0])) begin
              resp_err <= 1'b1;
              state    <= RESP;
            end else if (req_we && req_funct3 != F3_W) begin
              state <= RMW_RD;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q)
            resp_rdata <= extract(funct3_q, addr_q[1:0], mem_rdata);
          state <= RESP;
        end
        RMW_RD: begin
          merge_q <= mem_rdata;
          state   <= RMW_WR;
        end
        RMW_WR:  state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes come straight from the state register, so read and write are mutually exclusive.
  assign resp_valid = (state == RESP);
  assign mem_read   = (state == ACCESS && !we_q) || (state == RMW_RD);
  assign mem_write  = (state == ACCESS &&  we_q) || (state == RMW_WR);
  assign mem_addr   = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;

  // NOTE: always_comb assigns a default first so no path leaves the output unassigned (no latch).
  always_comb begin
    mem_wdata = 32'h0;
    if (state == ACCESS && we_q)
      mem_wdata = wdata_q;
    else if (state == RMW_WR)
      mem_wdata = merge(funct3_q, addr_q[1:0], merge_q, wdata_q);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Results of the last transaction
  logic [31:0] r_rdata, r_wdata, r_addr;
  logic        r_err, r_busy_ok, r_both;
  int          r_lat, r_rd, r_wr;

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    @(negedge clk);
    check("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    r_lat = 1; r_rd = 0; r_wr = 0; r_busy_ok = 1'b1; r_both = 1'b0;
    r_wdata = 32'h0; r_addr = 32'h0;
    while (!resp_valid && r_lat < 8) begin
      if (req_ready) r_busy_ok = 1'b0;
      if (mem_read && mem_write) r_both = 1'b1;
      if (mem_read) begin r_rd = r_lat; r_addr = mem_addr; end
      if (mem_write) begin r_wr = r_lat; r_addr = mem_addr; r_wdata = mem_wdata; end
      @(negedge clk);
      r_lat++;
    end
    if (req_ready || mem_read || mem_write) r_busy_ok = 1'b0;
    r_rdata = resp_rdata;
    r_err   = resp_err;
  endtask

  task automatic chk_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
    do_req(1'b0, f3, addr, 32'h0);
    check({tag, "_data"}, r_rdata, exp);
    check({tag, "_lat"}, r_lat, 2);
    check({tag, "_err"}, {31'h0, r_err}, 32'h0);
    check({tag, "_rdcyc"}, r_rd, 1);
    check({tag, "_wrcyc"}, r_wr, 0);
    check({tag, "_addr"}, r_addr, {addr[31:2], 2'b00});
  endtask

  task automatic chk_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
    do_req(we, f3, addr, 32'h0BAD_0BAD);
    check({tag, "_err"}, {31'h0, r_err}, 32'h1);
    check({tag, "_lat"}, r_lat, 1);
    check({tag, "_data"}, r_rdata, 32'h0);
    check({tag, "_strobes"}, r_rd + r_wr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic saw_bad;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    #1 check("rst_ready_after", {31'h0, req_ready}, 32'h1);

    // Preload via SW
    do_req(1'b1, 3'b010, 32'h0, 32'h8877_66F5);
    check("sw0_lat", r_lat, 2);
    check("sw0_wrcyc", r_wr, 1);
    check("sw0_rdcyc", r_rd, 0);
    check("sw0_wdata", r_wdata, 32'h8877_66F5);
    check("sw0_rdata", r_rdata, 32'h0);
    do_req(1'b1, 3'b010, 32'h4, 32'hCAFE_F00D);
    check("sw4_addr", r_addr, 32'h4);

    // Load extraction
    chk_load("lb0",  3'b000, 32'h0, 32'hFFFF_FFF5);
    chk_load("lbu0", 3'b100, 32'h0, 32'h0000_00F5);
    chk_load("lh2",  3'b001, 32'h2, 32'hFFFF_8877);
    chk_load("lhu2", 3'b101, 32'h2, 32'h0000_8877);
    chk_load("lb3",  3'b000, 32'h3, 32'hFFFF_FF88);
    chk_load("lbu1", 3'b100, 32'h1, 32'h0000_0066);
    chk_load("lw0",  3'b010, 32'h0, 32'h8877_66F5);

    // SB read-modify-write
    do_req(1'b1, 3'b010, 32'h0, 32'h1122_3344);
    do_req(1'b1, 3'b000, 32'h1, 32'hFFFF_FFAB);
    check("sb_lat", r_lat, 3);
    check("sb_rdcyc", r_rd, 1);
    check("sb_wrcyc", r_wr, 2);
    check("sb_wdata", r_wdata, 32'h1122_AB44);
    check("sb_rdata", r_rdata, 32'h0);
    check("sb_busy", {31'h0, r_busy_ok}, 32'h1);
    chk_load("lw_after_sb", 3'b010, 32'h0, 32'h1122_AB44);

    // SH read-modify-write on upper halfword
    do_req(1'b1, 3'b001, 32'h2, 32'hFFFF_1234);
    check("sh_lat", r_lat, 3);
    check("sh_wdata", r_wdata, 32'h1234_AB44);
    chk_load("lh_after_sh", 3'b001, 32'h2, 32'h0000_1234);
    chk_load("lh0",  3'b001, 32'h0, 32'hFFFF_AB44);
    chk_load("lhu0", 3'b101, 32'h0, 32'h0000_AB44);

    // SW then back-to-back LW
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    check("sw10_busy", {31'h0, r_busy_ok}, 32'h1);
    check("sw10_lat", r_lat, 2);
    chk_load("lw10", 3'b010, 32'h10, 32'hDEAD_BEEF);
    check("lw10_busy", {31'h0, r_busy_ok}, 32'h1);
    check("no_rd_wr_overlap", {31'h0, r_both}, 32'h0);

    // Misaligned word
`ifdef LSU_ALIGN_CHECK_EN
    chk_err("lw6_mis", 1'b0, 3'b010, 32'h6);
`else
    chk_load("lw6", 3'b010, 32'h6, 32'hCAFE_F00D);
`endif

    // Illegal funct3
    chk_err("ld_f3_111", 1'b0, 3'b111, 32'h0);
    chk_err("ld_f3_011", 1'b0, 3'b011, 32'h4);
    chk_err("st_f3_100", 1'b1, 3'b100, 32'h0);
    chk_load("lw0_untouched", 3'b010, 32'h0, 32'h1234_AB44);

    // Reset during RMW_RD of an SH
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12; req_wdata = 32'h5555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    check("rstmid_rmw_read", {31'h0, mem_read}, 32'h1);
    reset = 1'b1;
    #1 check("rstmid_ready_in_reset", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    saw_bad = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 check("rstmid_ready_after", {31'h0, req_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (mem_write || mem_read || resp_valid) saw_bad = 1'b1;
      @(negedge clk);
    end
    check("rstmid_quiet", {31'h0, saw_bad}, 32'h0);
    chk_load("rstmid_mem", 3'b010, 32'h10, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
